// File: rtl/kgp_core_pkg.sv
// kgp_core_pkg
// Shared definitions for the instruction-sequencing core.
//   state_t              : sequencer FSM encoding (IDLE, FETCH, ISSUE, EXEC, HALTED)
//   PC_STEP              : sequential PC increment (one 32-bit instruction word)
//   DEFAULT_RESET_VECTOR : default PC loaded on reset
package kgp_core_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    ISSUE  = 3'd2,
    EXEC   = 3'd3,
    HALTED = 3'd4
  } state_t;

  localparam logic [31:0] PC_STEP              = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Fetch / issue / execute sequencer holding the program counter. Each
// instruction is fetched from instruction memory, presented to decode until
// accepted, then held until execution reports completion, at which point the
// PC is redirected (taken branch/jump) or advanced by one word.
//
// Handshakes:
//   - ImemReq stays high for the whole FETCH state; the cycle that ImemAck is
//     high at a rising edge, InstrIn is captured. ImemAck in any other state
//     is ignored.
//   - InstrValid stays high for the whole ISSUE state; decode accepts on the
//     first rising edge with Stall=0. InstrOut/PCOut never change while
//     InstrValid=1.
//   - ExecDone is only looked at in EXEC; JCout, UncondJump, JumpAddr and Halt
//     are only meaningful on that same edge.
//
// Parameters:
//   RESET_VECTOR : PC loaded on reset
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   ImemReq, ImemAddr     : instruction read request and address (= PC)
//   ImemAck, InstrIn      : read completion and returned word
//   InstrOut, PCOut       : registered instruction and its PC
//   InstrValid            : InstrOut/PCOut valid for decode
//   Stall                 : decode back-pressure
//   ExecDone              : current instruction finished
//   JCout, UncondJump     : conditional-taken / unconditional jump
//   JumpAddr              : redirect target (word aligned on use)
//   Halt                  : current instruction is a halt
//   Halted                : sequencer stopped until reset
//   TakenCnt              : saturating count of taken redirects
//                           (only when TAKEN_COUNT_EN is defined)
//
// Build option: define TAKEN_COUNT_EN to add the TakenCnt output and counter.
module pc_sequencer
  import kgp_core_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] InstrIn,
  output logic [31:0] InstrOut,
  output logic        InstrValid,
  output logic [31:0] PCOut,
  input  logic        Stall,
  input  logic        ExecDone,
  input  logic        JCout,
  input  logic        UncondJump,
  input  logic [31:0] JumpAddr,
  input  logic        Halt,
  output logic        Halted
`ifdef TAKEN_COUNT_EN
  ,
  output logic [15:0] TakenCnt
`endif
);

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] instr_q;
  logic [31:0] pc_out_q;
  logic        capture;
  logic        retire;
  logic        taken;

  // Target low bits are discarded: redirects are always word aligned.
  logic        unused_jump_low;
  assign unused_jump_low = ^JumpAddr[1:0];

  assign taken   = JCout | UncondJump;
  // Plain 32-bit add: wraps from 32'hFFFF_FFFC to 32'h0000_0000.
  assign pc_next = taken ? {JumpAddr[31:2], 2'b00} : pc + PC_STEP;

  // Next-state logic. retire marks a completed non-halt instruction; a halt
  // wins over any branch and leaves the PC untouched.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    retire     = 1'b0;
    unique case (state)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        if (ImemAck) begin
          capture    = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (!Stall) begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (ExecDone) begin
          if (Halt) begin
            state_next = HALTED;
          end else begin
            retire     = 1'b1;
            state_next = FETCH;
          end
        end
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_VECTOR;
      instr_q  <= 32'h0000_0000;
      pc_out_q <= 32'h0000_0000;
    end else begin
      state <= state_next;
      if (retire) begin
        pc <= pc_next;
      end
      if (capture) begin
        instr_q  <= InstrIn;
        pc_out_q <= pc;
      end
    end
  end

  // Outputs decode only the registered state.
  assign ImemReq    = (state == FETCH);
  assign ImemAddr   = pc;
  assign InstrValid = (state == ISSUE);
  assign Halted     = (state == HALTED);
  assign InstrOut   = instr_q;
  assign PCOut      = pc_out_q;

`ifdef TAKEN_COUNT_EN
  logic [15:0] taken_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt <= 16'h0000;
    end else if (retire && taken && (taken_cnt != 16'hFFFF)) begin
      taken_cnt <= taken_cnt + 16'd1;
    end
  end

  assign TakenCnt = taken_cnt;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Bench for pc_sequencer: a directed cycle table, hand-written sequences for
// stall, halt and reset-in-fetch, then randomized traffic against a
// transaction-level reference model. A second instance with
// RESET_VECTOR=32'hFFFF_FFFC shares all inputs to show PC wrap-around.
// Define TAKEN_COUNT_EN to also check the taken-redirect counter.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        ImemAck;
  logic [31:0] InstrIn;
  logic        Stall;
  logic        ExecDone;
  logic        JCout;
  logic        UncondJump;
  logic [31:0] JumpAddr;
  logic        Halt;

  logic        req_a, valid_a, halted_a;
  logic [31:0] addr_a, iout_a, pout_a;
  logic        req_b, valid_b, halted_b;
  logic [31:0] addr_b, iout_b, pout_b;
`ifdef TAKEN_COUNT_EN
  logic [15:0] taken_a, taken_b;
`endif

  pc_sequencer #(.RESET_VECTOR(32'h0000_0000)) u_dut_a (
    .clk(clk), .rst(rst),
    .ImemReq(req_a), .ImemAddr(addr_a), .ImemAck(ImemAck), .InstrIn(InstrIn),
    .InstrOut(iout_a), .InstrValid(valid_a), .PCOut(pout_a),
    .Stall(Stall), .ExecDone(ExecDone), .JCout(JCout), .UncondJump(UncondJump),
    .JumpAddr(JumpAddr), .Halt(Halt), .Halted(halted_a)
`ifdef TAKEN_COUNT_EN
    , .TakenCnt(taken_a)
`endif
  );

  pc_sequencer #(.RESET_VECTOR(32'hFFFF_FFFC)) u_dut_b (
    .clk(clk), .rst(rst),
    .ImemReq(req_b), .ImemAddr(addr_b), .ImemAck(ImemAck), .InstrIn(InstrIn),
    .InstrOut(iout_b), .InstrValid(valid_b), .PCOut(pout_b),
    .Stall(Stall), .ExecDone(ExecDone), .JCout(JCout), .UncondJump(UncondJump),
    .JumpAddr(JumpAddr), .Halt(Halt), .Halted(halted_b)
`ifdef TAKEN_COUNT_EN
    , .TakenCnt(taken_b)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    ImemAck = 1'b0; InstrIn = 32'h0; Stall = 1'b0; ExecDone = 1'b0;
    JCout = 1'b0; UncondJump = 1'b0; JumpAddr = 32'h0; Halt = 1'b0;
  endtask

  // Inputs are driven and outputs sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    rst = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        ack;
    logic [31:0] instr;
    logic        stall;
    logic        done;
    logic        jc;
    logic        uj;
    logic [31:0] ja;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_addr_b;
    logic        e_valid;
    logic [31:0] e_iout;
    logic [31:0] e_pout;
    int          e_taken;
  } vec_t;

  vec_t vec_q[$];

  task automatic add_row(input logic ack, input logic [31:0] instr, input logic stall,
                         input logic done, input logic jc, input logic uj,
                         input logic [31:0] ja, input logic e_req,
                         input logic [31:0] e_addr, input logic [31:0] e_addr_b,
                         input logic e_valid, input logic [31:0] e_iout,
                         input logic [31:0] e_pout, input int e_taken);
    vec_t v;
    v.ack = ack; v.instr = instr; v.stall = stall; v.done = done;
    v.jc = jc; v.uj = uj; v.ja = ja;
    v.e_req = e_req; v.e_addr = e_addr; v.e_addr_b = e_addr_b;
    v.e_valid = e_valid; v.e_iout = e_iout; v.e_pout = e_pout; v.e_taken = e_taken;
    vec_q.push_back(v);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } issue_t;

  logic [31:0] exp_q[$];   // pending fetch addresses
  issue_t      iss_q[$];   // instruction waiting for decode
  bit          m_idle;
  bit          m_exec;
  bit          m_halted;
  logic [31:0] m_exec_pc;
  int          m_taken;

  task automatic model_reset();
    exp_q.delete();
    iss_q.delete();
    m_idle = 1'b1; m_exec = 1'b0; m_halted = 1'b0;
    m_exec_pc = 32'h0; m_taken = 0;
  endtask

  // Advance the model across one rising edge with the currently driven inputs.
  task automatic model_edge();
    issue_t it;
    if (rst) begin
      model_reset();
    end else if (m_idle) begin
      m_idle = 1'b0;
      exp_q.push_back(32'h0000_0000);
    end else if (exp_q.size() != 0) begin
      if (ImemAck) begin
        it.pc = exp_q.pop_front();
        it.instr = InstrIn;
        iss_q.push_back(it);
      end
    end else if (iss_q.size() != 0) begin
      if (!Stall) begin
        it = iss_q.pop_front();
        m_exec_pc = it.pc;
        m_exec = 1'b1;
      end
    end else if (m_exec && ExecDone) begin
      m_exec = 1'b0;
      if (Halt) begin
        m_halted = 1'b1;
      end else if (JCout || UncondJump) begin
        exp_q.push_back(JumpAddr & 32'hFFFF_FFFC);
        if (m_taken < 65535) m_taken++;
      end else begin
        exp_q.push_back(m_exec_pc + 32'd4);
      end
    end
  endtask

  task automatic model_compare();
    check("rnd_req", {31'd0, req_a}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) check("rnd_addr", addr_a, exp_q[0]);
    check("rnd_valid", {31'd0, valid_a}, {31'd0, iss_q.size() != 0});
    if (iss_q.size() != 0) begin
      check("rnd_iout", iout_a, iss_q[0].instr);
      check("rnd_pout", pout_a, iss_q[0].pc);
    end
    check("rnd_halted", {31'd0, halted_a}, {31'd0, m_halted});
`ifdef TAKEN_COUNT_EN
    check("rnd_taken", {16'd0, taken_a}, m_taken);
`endif
  endtask

  // ---------------- test body ----------------
  initial begin
    vec_t v;
    int   vcount;
    int   halt_cycles;

    rst = 1'b1;
    clear_inputs();
    @(negedge clk);

    // Sequential run 0,4,8,C, ignored acks/dones, then taken redirects.
    //      ack instr          stl dn jc uj ja            req addr          addr_b        vld iout           pout          tk
    add_row(1, 32'hDEAD_BEEF, 0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        0);
    add_row(1, 32'h1111_0000, 0, 0, 0, 0, 32'h0,        1, 32'h0,        32'hFFFF_FFFC, 0, 32'h0,       32'h0,        0);
    add_row(0, 32'h0,         0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h1111_0000, 32'h0,       0);
    add_row(1, 32'hBAD0_BAD0, 0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        0);
    add_row(1, 32'h1111_0001, 0, 0, 0, 0, 32'h0,        1, 32'h4,        32'h0,        0, 32'h0,        32'h0,        0);
    add_row(0, 32'h0,         0, 1, 1, 0, 32'h40,       0, 32'h0,        32'h0,        1, 32'h1111_0001, 32'h4,       0);
    add_row(0, 32'h0,         0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        0);
    add_row(1, 32'h1111_0002, 0, 0, 0, 0, 32'h0,        1, 32'h8,        32'h4,        0, 32'h0,        32'h0,        0);
    add_row(0, 32'h0,         0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h1111_0002, 32'h8,       0);
    add_row(0, 32'h0,         0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        0);
    add_row(1, 32'h1111_0003, 0, 0, 0, 0, 32'h0,        1, 32'hC,        32'h8,        0, 32'h0,        32'h0,        0);
    add_row(0, 32'h0,         0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h1111_0003, 32'hC,       0);
    add_row(0, 32'h0,         0, 1, 1, 0, 32'h103,      0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        0);
    add_row(0, 32'h0,         0, 0, 0, 0, 32'h0,        1, 32'h100,      32'h100,      0, 32'h0,        32'h0,        1);
    add_row(1, 32'h1111_0004, 0, 0, 0, 0, 32'h0,        1, 32'h100,      32'h100,      0, 32'h0,        32'h0,        1);
    add_row(0, 32'h0,         0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h1111_0004, 32'h100,     1);
    add_row(0, 32'h0,         0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        1);
    add_row(0, 32'h0,         0, 1, 0, 1, 32'h207,      0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        1);
    add_row(0, 32'h0,         0, 0, 0, 0, 32'h0,        1, 32'h204,      32'h204,      0, 32'h0,        32'h0,        2);

    do_reset();
    check("rst_iout", iout_a, 32'h0);
    check("rst_pout", pout_a, 32'h0);
    for (int i = 0; i < vec_q.size(); i++) begin
      v = vec_q[i];
      check($sformatf("tbl%0d_req", i), {31'd0, req_a}, {31'd0, v.e_req});
      if (v.e_req) begin
        check($sformatf("tbl%0d_addr", i), addr_a, v.e_addr);
        check($sformatf("tbl%0d_addr_b", i), addr_b, v.e_addr_b);
      end
      check($sformatf("tbl%0d_valid", i), {31'd0, valid_a}, {31'd0, v.e_valid});
      if (v.e_valid) begin
        check($sformatf("tbl%0d_iout", i), iout_a, v.e_iout);
        check($sformatf("tbl%0d_pout", i), pout_a, v.e_pout);
      end
      check($sformatf("tbl%0d_halted", i), {31'd0, halted_a}, 32'd0);
`ifdef TAKEN_COUNT_EN
      check($sformatf("tbl%0d_taken", i), {16'd0, taken_a}, v.e_taken);
`endif
      ImemAck = v.ack; InstrIn = v.instr; Stall = v.stall; ExecDone = v.done;
      JCout = v.jc; UncondJump = v.uj; JumpAddr = v.ja; Halt = 1'b0;
      step();
    end
    clear_inputs();

    // Stall for three cycles in ISSUE, then halt with a competing jump.
    do_reset();
    step();
    check("stall_fetch_req", {31'd0, req_a}, 32'd1);
    ImemAck = 1'b1; InstrIn = 32'hCAFE_0001;
    step();
    ImemAck = 1'b0;
    vcount = 0;
    for (int k = 0; k < 4; k++) begin
      Stall = (k < 3);
      if (valid_a) vcount++;
      check("stall_iout", iout_a, 32'hCAFE_0001);
      check("stall_pout", pout_a, 32'h0);
      check("stall_req", {31'd0, req_a}, 32'd0);
      step();
    end
    Stall = 1'b0;
    check("stall_valid_cycles", vcount, 4);
    check("stall_exit_valid", {31'd0, valid_a}, 32'd0);

    ExecDone = 1'b1; Halt = 1'b1; UncondJump = 1'b1; JCout = 1'b1; JumpAddr = 32'h500;
    step();
    Halt = 1'b0; ImemAck = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("halt_halted", {31'd0, halted_a}, 32'd1);
      check("halt_req", {31'd0, req_a}, 32'd0);
      check("halt_valid", {31'd0, valid_a}, 32'd0);
      check("halt_pout", pout_a, 32'h0);
`ifdef TAKEN_COUNT_EN
      check("halt_taken", {16'd0, taken_a}, 32'd0);
`endif
      step();
    end
    clear_inputs();

    // Reset while fetching from PC=4, with an ack arriving the next cycle.
    do_reset();
    step();
    ImemAck = 1'b1; InstrIn = 32'h2222_0000;
    step();
    ImemAck = 1'b0;
    step();
    ExecDone = 1'b1;
    step();
    ExecDone = 1'b0;
    check("rf_fetch_req", {31'd0, req_a}, 32'd1);
    check("rf_fetch_addr", addr_a, 32'h4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    ImemAck = 1'b1; InstrIn = 32'h3333_3333;
    check("rf_idle_req", {31'd0, req_a}, 32'd0);
    check("rf_idle_valid", {31'd0, valid_a}, 32'd0);
    check("rf_idle_iout", iout_a, 32'h0);
    check("rf_idle_pout", pout_a, 32'h0);
    step();
    check("rf_refetch_req", {31'd0, req_a}, 32'd1);
    check("rf_refetch_valid", {31'd0, valid_a}, 32'd0);
    check("rf_refetch_addr", addr_a, 32'h0);
    check("rf_refetch_addr_b", addr_b, 32'hFFFF_FFFC);
    InstrIn = 32'h4444_0000;
    step();
    clear_inputs();
    check("rf_issue_valid", {31'd0, valid_a}, 32'd1);
    check("rf_issue_iout", iout_a, 32'h4444_0000);
    check("rf_issue_pout", pout_a, 32'h0);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    halt_cycles = 0;
    for (int c = 0; c < 3000; c++) begin
      model_compare();
      halt_cycles = m_halted ? halt_cycles + 1 : 0;
      rst        = (halt_cycles >= 6) || ($urandom_range(0, 299) == 0);
      ImemAck    = ($urandom_range(0, 2) != 0);
      InstrIn    = $urandom;
      Stall      = ($urandom_range(0, 2) == 0);
      ExecDone   = ($urandom_range(0, 1) == 1);
      JCout      = ($urandom_range(0, 3) == 0);
      UncondJump = ($urandom_range(0, 7) == 0);
      JumpAddr   = $urandom;
      Halt       = ($urandom_range(0, 29) == 0);
      model_edge();
      step();
    end
    rst = 1'b0;
    clear_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
